// File: rtl/cuckoo_lookup.sv
// Read-side lookup engine for a two-table cuckoo hash store: probes table1, then table2, and reports hit/table/index.
// Optional hit/miss counters are built when CUCKOO_LOOKUP_STATS_EN is defined.
module cuckoo_lookup #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
`ifdef CUCKOO_LOOKUP_STATS_EN
  ,
  parameter int unsigned STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  input  logic [IDX_W-1:0]  req_idx1,
  input  logic [IDX_W-1:0]  req_idx2,
  output logic              t1_rd_en,
  output logic [IDX_W-1:0]  t1_rd_addr,
  input  logic [DATA_W-1:0] t1_rd_data,
  input  logic              t1_rd_filled,
  output logic              t2_rd_en,
  output logic [IDX_W-1:0]  t2_rd_addr,
  input  logic [DATA_W-1:0] t2_rd_data,
  input  logic              t2_rd_filled,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_table,
  output logic [IDX_W-1:0]  rsp_index,
  output logic [DATA_W-1:0] rsp_key
`ifdef CUCKOO_LOOKUP_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_CMP1 = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_CMP2 = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [IDX_W-1:0]  idx1_q, idx1_d;
  logic [IDX_W-1:0]  idx2_q, idx2_d;

  logic              req_ready_d;
  logic              t1_rd_en_d, t2_rd_en_d;
  logic [IDX_W-1:0]  t1_rd_addr_d, t2_rd_addr_d;
  logic              rsp_valid_d, rsp_hit_d, rsp_table_d;
  logic [IDX_W-1:0]  rsp_index_d;
  logic [DATA_W-1:0] rsp_key_d;

  logic t1_match_c, t2_match_c;

  // An empty slot never matches, even if its stale data equals the key.
  assign t1_match_c = t1_rd_filled && (t1_rd_data == key_q);
  assign t2_match_c = t2_rd_filled && (t2_rd_data == key_q);

  // Next-state and next-output logic; strobes are raised on entry to RD1/RD2 so they are high in those states.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    idx1_d       = idx1_q;
    idx2_d       = idx2_q;
    req_ready_d  = req_ready;
    t1_rd_en_d   = 1'b0;
    t2_rd_en_d   = 1'b0;
    t1_rd_addr_d = t1_rd_addr;
    t2_rd_addr_d = t2_rd_addr;
    rsp_valid_d  = rsp_valid;
    rsp_hit_d    = rsp_hit;
    rsp_table_d  = rsp_table;
    rsp_index_d  = rsp_index;
    rsp_key_d    = rsp_key;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          key_d        = req_key;
          idx1_d       = req_idx1;
          idx2_d       = req_idx2;
          req_ready_d  = 1'b0;
          t1_rd_en_d   = 1'b1;
          t1_rd_addr_d = req_idx1;
          state_d      = S_RD1;
        end
      end
      S_RD1: state_d = S_CMP1;
      S_CMP1: begin
        if (t1_match_c) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_table_d = 1'b0;
          rsp_index_d = idx1_q;
          rsp_key_d   = key_q;
          state_d     = S_RESP;
        end else begin
          t2_rd_en_d   = 1'b1;
          t2_rd_addr_d = idx2_q;
          state_d      = S_RD2;
        end
      end
      S_RD2: state_d = S_CMP2;
      S_CMP2: begin
        rsp_valid_d = 1'b1;
        rsp_key_d   = key_q;
        if (t2_match_c) begin
          rsp_hit_d   = 1'b1;
          rsp_table_d = 1'b1;
          rsp_index_d = idx2_q;
        end else begin
          rsp_hit_d   = 1'b0;
          rsp_table_d = 1'b0;
          rsp_index_d = '0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      req_ready  <= 1'b1;
      t1_rd_en   <= 1'b0;
      t2_rd_en   <= 1'b0;
      t1_rd_addr <= '0;
      t2_rd_addr <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_table  <= 1'b0;
      rsp_index  <= '0;
      rsp_key    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      req_ready  <= req_ready_d;
      t1_rd_en   <= t1_rd_en_d;
      t2_rd_en   <= t2_rd_en_d;
      t1_rd_addr <= t1_rd_addr_d;
      t2_rd_addr <= t2_rd_addr_d;
      rsp_valid  <= rsp_valid_d;
      rsp_hit    <= rsp_hit_d;
      rsp_table  <= rsp_table_d;
      rsp_index  <= rsp_index_d;
      rsp_key    <= rsp_key_d;
    end
  end

`ifdef CUCKOO_LOOKUP_STATS_EN
  logic rsp_fire_c;
  assign rsp_fire_c = rsp_valid && rsp_ready;

  // Saturating hit/miss counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rsp_fire_c) begin
      if (rsp_hit && (hit_count != {STAT_W{1'b1}}))
        hit_count <= hit_count + STAT_W'(1);
      if (!rsp_hit && (miss_count != {STAT_W{1'b1}}))
        miss_count <= miss_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Bench for cuckoo_lookup: directed and randomized lookups against array-backed tables and a reference lookup model.
module tb_cuckoo_lookup;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic [DATA_W-1:0] req_key;
  logic [IDX_W-1:0]  req_idx1, req_idx2;
  logic              t1_rd_en, t2_rd_en;
  logic [IDX_W-1:0]  t1_rd_addr, t2_rd_addr;
  logic [DATA_W-1:0] t1_rd_data, t2_rd_data;
  logic              t1_rd_filled, t2_rd_filled;
  logic              rsp_valid, rsp_ready, rsp_hit, rsp_table;
  logic [IDX_W-1:0]  rsp_index;
  logic [DATA_W-1:0] rsp_key;
`ifdef CUCKOO_LOOKUP_STATS_EN
  logic              stats_clr;
  logic [15:0]       hit_count, miss_count;
`endif

  cuckoo_lookup dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .req_idx1(req_idx1), .req_idx2(req_idx2),
    .t1_rd_en(t1_rd_en), .t1_rd_addr(t1_rd_addr), .t1_rd_data(t1_rd_data), .t1_rd_filled(t1_rd_filled),
    .t2_rd_en(t2_rd_en), .t2_rd_addr(t2_rd_addr), .t2_rd_data(t2_rd_data), .t2_rd_filled(t2_rd_filled),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_table(rsp_table),
    .rsp_index(rsp_index), .rsp_key(rsp_key)
`ifdef CUCKOO_LOOKUP_STATS_EN
    , .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  logic              fill1 [DEPTH];
  logic              fill2 [DEPTH];

  // Synchronous-read tables; outside a read cycle the data bus carries junk.
  always @(posedge clk) begin
    if (t1_rd_en) begin
      t1_rd_data   <= mem1[t1_rd_addr];
      t1_rd_filled <= fill1[t1_rd_addr];
    end else begin
      t1_rd_data   <= $urandom;
      t1_rd_filled <= 1'($urandom_range(0, 1));
    end
    if (t2_rd_en) begin
      t2_rd_data   <= mem2[t2_rd_addr];
      t2_rd_filled <= fill2[t2_rd_addr];
    end else begin
      t2_rd_data   <= $urandom;
      t2_rd_filled <= 1'($urandom_range(0, 1));
    end
  end

  int t1_cnt = 0, t2_cnt = 0, both_cnt = 0;
  logic [IDX_W-1:0] t1_last = '0, t2_last = '0;

  // Strobe monitor.
  always @(posedge clk) begin
    if (t1_rd_en) begin t1_cnt++; t1_last = t1_rd_addr; end
    if (t2_rd_en) begin t2_cnt++; t2_last = t2_rd_addr; end
    if (t1_rd_en && t2_rd_en) both_cnt++;
  end

  int checks = 0;
  int errors = 0;
  int exp_hits = 0, exp_miss = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one lookup and check it against the reference model; completes the handshake if rsp_ready is high.
  task automatic lookup(input logic [DATA_W-1:0] key, input logic [IDX_W-1:0] i1, input logic [IDX_W-1:0] i2);
    logic h1, h2, exp_hit, exp_tab;
    logic [IDX_W-1:0] exp_idx;
    int exp_lat, edges, s1, s2;
    h1 = fill1[i1] && (mem1[i1] == key);
    h2 = fill2[i2] && (mem2[i2] == key);
    exp_hit = h1 || h2;
    exp_tab = !h1 && h2;
    exp_idx = h1 ? i1 : (h2 ? i2 : '0);
    exp_lat = h1 ? 3 : 5;
    s1 = t1_cnt;
    s2 = t2_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_key = key; req_idx1 = i1; req_idx2 = i2;
    @(posedge clk); #1;
    req_valid = 1'b0; req_key = ~key; req_idx1 = ~i1; req_idx2 = ~i2;
    edges = 1;
    while (!rsp_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(exp_lat));
    check("rsp_hit", 64'(rsp_hit), 64'(exp_hit));
    check("rsp_table", 64'(rsp_table), 64'(exp_tab));
    check("rsp_index", 64'(rsp_index), 64'(exp_idx));
    check("rsp_key", 64'(rsp_key), 64'(key));
    check("t1_reads", 64'(t1_cnt - s1), 64'd1);
    check("t1_addr", 64'(t1_last), 64'(i1));
    check("t2_reads", 64'(t2_cnt - s2), h1 ? 64'd0 : 64'd1);
    if (!h1) check("t2_addr", 64'(t2_last), 64'(i2));
    if (rsp_ready) begin
      @(posedge clk); #1;
      check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
      check("req_ready_back", 64'(req_ready), 64'd1);
      if (exp_hit) exp_hits++; else exp_miss++;
    end
  endtask

  logic [DATA_W-1:0] k;
  logic [IDX_W-1:0]  a, b;
  logic              sh, st;
  logic [IDX_W-1:0]  si;
  int                s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem1[i] = $urandom; fill1[i] = 1'($urandom_range(0, 1));
      mem2[i] = $urandom; fill2[i] = 1'($urandom_range(0, 1));
    end
    reset = 1'b0; req_valid = 1'b0; req_key = '0; req_idx1 = '0; req_idx2 = '0; rsp_ready = 1'b1;
`ifdef CUCKOO_LOOKUP_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_t1_en", 64'(t1_rd_en), 64'd0);
    check("rst_t2_en", 64'(t2_rd_en), 64'd0);
    check("rst_addrs", 64'({t1_rd_addr, t2_rd_addr}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_hit, rsp_table, rsp_index}), 64'd0);
    check("rst_rsp_key", 64'(rsp_key), 64'd0);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_strobes", 64'(t1_cnt + t2_cnt), 64'd0);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Table1 hit.
    mem1[3] = 32'hDEADBEEF; fill1[3] = 1'b1;
    mem2[17] = 32'h0; fill2[17] = 1'b0;
    lookup(32'hDEADBEEF, 5'd3, 5'd17);
    // Table2 hit.
    mem1[3] = 32'h12345678;
    mem2[17] = 32'hDEADBEEF; fill2[17] = 1'b1;
    lookup(32'hDEADBEEF, 5'd3, 5'd17);
    // Key 0 against empty slots holding 0 is a miss.
    mem1[0] = 32'h0; fill1[0] = 1'b0;
    mem2[9] = 32'h0; fill2[9] = 1'b0;
    lookup(32'h0, 5'd0, 5'd9);
    // Key 0 present in table2.
    fill2[9] = 1'b1;
    lookup(32'h0, 5'd0, 5'd9);
    // Present in both tables: table1 wins.
    mem1[12] = 32'hCAFEF00D; fill1[12] = 1'b1;
    mem2[12] = 32'hCAFEF00D; fill2[12] = 1'b1;
    lookup(32'hCAFEF00D, 5'd12, 5'd12);
    // idx1 == idx2, only table2 holds it: both reads happen.
    fill1[12] = 1'b0;
    lookup(32'hCAFEF00D, 5'd12, 5'd12);

    // Randomized lookups with planted keys.
    for (int n = 0; n < 40; n++) begin
      k = $urandom;
      a = IDX_W'($urandom_range(0, DEPTH - 1));
      b = IDX_W'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 4))
        0: begin mem1[a] = k; fill1[a] = 1'b1; end
        1: begin mem2[b] = k; fill2[b] = 1'b1; end
        2: begin mem1[a] = k; fill1[a] = 1'b1; mem2[b] = k; fill2[b] = 1'b1; end
        3: begin mem1[a] = k; fill1[a] = 1'b0; mem2[b] = k; fill2[b] = 1'b0; end
        default: ;
      endcase
      lookup(k, a, b);
    end

    // Back-pressure: response held while a new request is offered.
    rsp_ready = 1'b0;
    mem1[5] = 32'hA5A5A5A5; fill1[5] = 1'b1;
    lookup(32'hA5A5A5A5, 5'd5, 5'd6);
    sh = rsp_hit; st = rsp_table; si = rsp_index;
    repeat (4) begin
      @(negedge clk);
      req_valid = 1'b1; req_key = 32'h11111111; req_idx1 = 5'd7; req_idx2 = 5'd8;
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_fields", 64'({rsp_hit, rsp_table, rsp_index}), 64'({sh, st, si}));
      check("hold_key", 64'(rsp_key), 64'h0A5A5A5A5);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    s = t1_cnt;
    @(posedge clk); #1;
    check("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    check("hs_req_ready", 64'(req_ready), 64'd1);
    exp_hits++;
    @(posedge clk); #1;
    check("no_stale_accept", 64'(t1_cnt - s), 64'd0);
    check("no_stale_t1_en", 64'(t1_rd_en), 64'd0);

    // Reset during RD2 aborts the lookup.
    fill1[2] = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_key = 32'h77777777; req_idx1 = 5'd2; req_idx2 = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rd2_t2_en", 64'(t2_rd_en), 64'd1);
    reset = 1'b0;
    #1;
    exp_hits = 0; exp_miss = 0;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_strobes", 64'({t1_rd_en, t2_rd_en}), 64'd0);
    check("abort_addrs", 64'({t1_rd_addr, t2_rd_addr}), 64'd0);
    check("abort_rsp_fields", 64'({rsp_hit, rsp_table, rsp_index}), 64'd0);
    check("abort_rsp_key", 64'(rsp_key), 64'd0);
    @(negedge clk); reset = 1'b1;
    s = t2_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    check("abort_no_reads", 64'(t2_cnt - s), 64'd0);

`ifdef CUCKOO_LOOKUP_STATS_EN
    check("stats_hits_after_reset", 64'(hit_count), 64'(exp_hits));
    mem1[20] = 32'h00000020; fill1[20] = 1'b1;
    mem2[21] = 32'h00000021; fill2[21] = 1'b1;
    fill1[22] = 1'b0; fill2[23] = 1'b0;
    lookup(32'h00000020, 5'd20, 5'd1);
    lookup(32'h00000021, 5'd22, 5'd21);
    lookup(32'h00000099, 5'd22, 5'd23);
    check("hit_count", 64'(hit_count), 64'(exp_hits));
    check("miss_count", 64'(miss_count), 64'(exp_miss));
    check("hit_count_two", 64'(hit_count), 64'd2);
    @(negedge clk); stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    check("clr_hit_count", 64'(hit_count), 64'd0);
    check("clr_miss_count", 64'(miss_count), 64'd0);
`endif

    check("strobe_overlap", 64'(both_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
